// File: rtl/iic_reg_access_if.sv
// Register-port bus between the transaction sequencer and iic_core.
// The master side drives strobes and address/data; the slave side returns readdata.
interface iic_reg_access_if;
  logic [3:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_read;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_write, m_writedata, m_read,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_writedata, m_read,
    output m_readdata
  );
endinterface

// File: rtl/iic_reg_access.sv
// iic_reg_access: expands one I2C register read/write request into the iic_core command
// sequence (SCL setup, START, WRITE, READ, STOP), polling busy and checking ACK per byte.
module iic_reg_access #(
  parameter logic [7:0]  SCL_PERIOD = 8'd63,
  parameter int          GUARD_CYC  = 3,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             rnw,
  input  logic [6:0]       dev_addr,
  input  logic [7:0]       reg_addr,
  input  logic [7:0]       wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       rdata,
  iic_reg_access_if.master bus
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_ISSUE = 3'd2,
    S_GUARD = 3'd3,
    S_POLL  = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Command word {op, byte} for a given step of the write or read sequence.
  function automatic logic [9:0] step_word(input logic rd, input logic [2:0] idx,
                                           input logic [6:0] dev, input logic [7:0] ra,
                                           input logic [7:0] wd);
    logic [9:0] w;
    w = {OP_STOP, 8'h00};
    if (rd) begin
      case (idx)
        3'd0, 3'd3: w = {OP_START, 8'h00};
        3'd1:       w = {OP_WRITE, dev, 1'b0};
        3'd2:       w = {OP_WRITE, ra};
        3'd4:       w = {OP_WRITE, dev, 1'b1};
        3'd5:       w = {OP_READ, 8'h01};
        default:    w = {OP_STOP, 8'h00};
      endcase
    end else begin
      case (idx)
        3'd0:    w = {OP_START, 8'h00};
        3'd1:    w = {OP_WRITE, dev, 1'b0};
        3'd2:    w = {OP_WRITE, ra};
        3'd3:    w = {OP_WRITE, wd};
        default: w = {OP_STOP, 8'h00};
      endcase
    end
    return w;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [3:0]  m_address_q, m_address_d;
  logic        m_chipselect_q, m_chipselect_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_writedata_q, m_writedata_d;
  logic        m_read_q, m_read_d;

  logic [9:0]  cur_word_s;
  logic [1:0]  cur_op_s;
  logic [2:0]  last_step_s;
  logic [16:0] poll_inc_s;
  logic        rd_busy_s, rd_ack_s;
  logic [7:0]  rd_data_s;
  logic        unused_readdata;

  assign cur_word_s      = step_word(rnw_q, step_q, dev_q, reg_q, wdata_q);
  assign cur_op_s        = cur_word_s[9:8];
  assign last_step_s     = rnw_q ? 3'd6 : 3'd4;
  assign poll_inc_s      = {1'b0, poll_cnt_q} + 17'd1;
  assign rd_busy_s       = bus.m_readdata[8];
  assign rd_ack_s        = bus.m_readdata[10];
  assign rd_data_s       = bus.m_readdata[7:0];
  assign unused_readdata = ^{bus.m_readdata[31:11], bus.m_readdata[9]};

  // Next-state sequencing, then bus strobes derived from the state being entered.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    guard_cnt_d = guard_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    cfg_pend_d  = cfg_pend_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_CFG;
          rnw_d   = rnw;
          dev_d   = dev_addr;
          reg_d   = reg_addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          step_d  = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        state_d     = S_GUARD;
        guard_cnt_d = GUARD_LOAD;
        poll_cnt_d  = 16'd0;
        cfg_pend_d  = 1'b1;
      end
      S_ISSUE: begin
        state_d     = S_GUARD;
        guard_cnt_d = GUARD_LOAD;
        poll_cnt_d  = 16'd0;
      end
      S_GUARD: begin
        if (guard_cnt_q == 8'd0) begin
          state_d = S_POLL;
        end else begin
          guard_cnt_d = guard_cnt_q - 8'd1;
        end
      end
      S_POLL: begin
        state_d = S_CHK;
      end
      S_CHK: begin
        if (rd_busy_s) begin
          // Timeout abandons the bus without STOP; the core's own reset recovers it.
          if (poll_inc_s == {1'b0, POLL_LIMIT}) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            poll_cnt_d = poll_inc_s[15:0];
            state_d    = S_POLL;
          end
        end else if (cfg_pend_q) begin
          cfg_pend_d = 1'b0;
          state_d    = S_ISSUE;
        end else if ((cur_op_s == OP_WRITE) && rd_ack_s) begin
          err_d   = 1'b1;
          step_d  = last_step_s;
          state_d = S_ISSUE;
        end else begin
          if (cur_op_s == OP_READ) begin
            rdata_d = rd_data_s;
          end else begin
            rdata_d = rdata_q;
          end
          if (step_q == last_step_s) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    m_write_d      = (state_d == S_CFG) || (state_d == S_ISSUE);
    m_read_d       = (state_d == S_POLL);
    m_chipselect_d = m_write_d || m_read_d;
    // Address 1 is held through the cycle after the SCL setup strobe.
    if ((state_d == S_CFG) || (state_q == S_CFG)) begin
      m_address_d = 4'd1;
    end else begin
      m_address_d = 4'd0;
    end
    if (state_d == S_CFG) begin
      m_writedata_d = {24'h000000, SCL_PERIOD};
    end else if (state_d == S_ISSUE) begin
      m_writedata_d = {22'h000000, step_word(rnw_d, step_d, dev_d, reg_d, wdata_d)};
    end else begin
      m_writedata_d = 32'h00000000;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Sequencer state and registered outputs; all flops clear on asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      step_q         <= 3'd0;
      guard_cnt_q    <= 8'd0;
      poll_cnt_q     <= 16'd0;
      cfg_pend_q     <= 1'b0;
      rnw_q          <= 1'b0;
      dev_q          <= 7'd0;
      reg_q          <= 8'd0;
      wdata_q        <= 8'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= 8'd0;
      m_address_q    <= 4'd0;
      m_chipselect_q <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= 32'h00000000;
      m_read_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      guard_cnt_q    <= guard_cnt_d;
      poll_cnt_q     <= poll_cnt_d;
      cfg_pend_q     <= cfg_pend_d;
      rnw_q          <= rnw_d;
      dev_q          <= dev_d;
      reg_q          <= reg_d;
      wdata_q        <= wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      m_address_q    <= m_address_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_q      <= m_write_d;
      m_writedata_q  <= m_writedata_d;
      m_read_q       <= m_read_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign rdata            = rdata_q;
  assign bus.m_address    = m_address_q;
  assign bus.m_chipselect = m_chipselect_q;
  assign bus.m_write      = m_write_q;
  assign bus.m_writedata  = m_writedata_q;
  assign bus.m_read       = m_read_q;

endmodule

// File: tb/tb_iic_reg_access.sv
// Bench for iic_reg_access: a behavioural iic_core model answers polls, logs command
// writes and checks bus timing; expected command lists come from the request alone.
module tb_iic_reg_access;
  localparam int GUARD = 3;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, rnw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wdata;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic       req2, busy2, done2, err2;
  logic [7:0] rdata2;

  int checks = 0;
  int errors = 0;

  // Core model state
  int          busy_polls = 0;
  int          nack_at = -1;
  logic [7:0]  read_val = 8'h00;
  int          cmd_idx = 0;
  logic [1:0]  last_op = OP_START;
  int          pending = 0;
  bit          seen_idle = 1'b0;
  bit          prev_strobe = 1'b0;
  int          since_write = 100;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  int          w2 = 0;
  int          r2 = 0;
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  iic_reg_access_if bus ();
  iic_reg_access_if bus2 ();

  iic_reg_access #(.SCL_PERIOD(8'd63), .GUARD_CYC(GUARD), .POLL_LIMIT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata), .bus(bus)
  );

  iic_reg_access #(.SCL_PERIOD(8'd63), .GUARD_CYC(GUARD), .POLL_LIMIT(16'd4)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .rnw(1'b0), .dev_addr(7'h22), .reg_addr(8'h01),
    .wdata(8'h5A), .busy(busy2), .done(done2), .err(err2), .rdata(rdata2), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Behavioural core: answers polls a cycle later, logs writes, checks strobe spacing.
  always @(negedge clk) begin
    logic bsy, ack;
    if (rst) begin
      pending = 0;
      seen_idle = 1'b0;
      prev_strobe = 1'b0;
      since_write = 100;
      bus.m_readdata = 32'h0;
    end else begin
      if (done) done_cnt++;
      if (bus.m_write || bus.m_read) begin
        strobe_cnt++;
        chk("single_strobe", {31'h0, bus.m_write & bus.m_read}, 32'h0);
        chk("chipselect", {31'h0, bus.m_chipselect}, 32'h1);
        chk("adjacent_strobe", {31'h0, prev_strobe}, 32'h0);
        if (bus.m_read) begin
          chk("guard_gap", {31'h0, since_write > GUARD}, 32'h1);
          chk("read_addr", {28'h0, bus.m_address}, 32'h0);
          bsy = (pending > 0);
          if (bsy) pending--;
          else seen_idle = 1'b1;
          ack = (last_op == OP_WRITE) && ((cmd_idx - 1) == nack_at);
          bus.m_readdata = {21'h0, ack, 1'b0, bsy, (last_op == OP_READ) ? read_val : 8'h00};
        end else begin
          chk("wdata_upper", {10'h0, bus.m_writedata[31:10]}, 32'h0);
          log_q.push_back({bus.m_address, 2'b00, bus.m_writedata[9:0]});
          if (bus.m_address == 4'd0) begin
            chk("cmd_after_idle_poll", {31'h0, seen_idle}, 32'h1);
            last_op = bus.m_writedata[9:8];
            cmd_idx++;
          end else begin
            last_op = OP_START;
          end
          pending = busy_polls;
          seen_idle = 1'b0;
          since_write = 0;
        end
      end
      prev_strobe = bus.m_write || bus.m_read;
      since_write++;
      if (bus2.m_write) w2++;
      if (bus2.m_read) r2++;
    end
  end

  // Expected write log straight from the request: setup, command list, NACK truncation.
  task automatic build_exp(input bit r, input logic [6:0] d, input logic [7:0] ra,
                           input logic [7:0] wd, input int nack);
    logic [9:0] cmds[$];
    exp_q.delete();
    cmds.push_back(10'h100);
    cmds.push_back({2'b00, d, 1'b0});
    cmds.push_back({2'b00, ra});
    if (r) begin
      cmds.push_back(10'h100);
      cmds.push_back({2'b00, d, 1'b1});
      cmds.push_back(10'h301);
    end else begin
      cmds.push_back({2'b00, wd});
    end
    cmds.push_back(10'h200);
    exp_q.push_back(16'h103F);
    for (int i = 0; i < cmds.size(); i++) begin
      exp_q.push_back({6'h00, cmds[i]});
      if (i == nack) begin
        exp_q.push_back(16'h0200);
        break;
      end
    end
  endtask

  task automatic run_req(input string name, input bit r, input logic [6:0] d,
                         input logic [7:0] ra, input logic [7:0] wd, input logic [7:0] rv,
                         input int bp, input int nack, input bit req_at_done, input bit req_mid);
    int cyc;
    busy_polls = bp;
    nack_at = nack;
    read_val = rv;
    cmd_idx = 0;
    log_q.delete();
    done_cnt = 0;
    build_exp(r, d, ra, wd, nack);
    @(negedge clk);
    rnw = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk({name, "_busy_start"}, {31'h0, busy}, 32'h1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (req_mid && cyc == 20) begin
        req = 1'b1; rnw = ~r; dev_addr = 7'h7F;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    chk({name, "_done_seen"}, {31'h0, done}, 32'h1);
    chk({name, "_err"}, {31'h0, err}, {31'h0, nack >= 0});
    chk({name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    if (r && nack < 0) chk({name, "_rdata"}, {24'h0, rdata}, {24'h0, rv});
    if (req_at_done) req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_idle_after"}, {31'h0, busy}, 32'h0);
    chk({name, "_err_held"}, {31'h0, err}, {31'h0, nack >= 0});
    chk({name, "_log_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({name, "_log_entry"}, {16'h0, log_q[i]}, {16'h0, exp_q[i]});
  endtask

  initial begin
    bit         r;
    logic [6:0] d;
    logic [7:0] ra, wd, rv;
    int         bp, nk, cyc, sc;
    rst = 1'b1; req = 1'b0; req2 = 1'b0; rnw = 1'b0;
    dev_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
    bus2.m_readdata = 32'h0000_0100;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", {24'h0, rdata}, 32'h0);
    chk("rst_m_ctl", {25'h0, bus.m_address, bus.m_chipselect, bus.m_write, bus.m_read}, 32'h0);
    chk("rst_m_wdata", bus.m_writedata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_req("t1_write", 1'b0, 7'h50, 8'h12, 8'h34, 8'h00, 0, -1, 1'b1, 1'b0);
    run_req("t2_read", 1'b1, 7'h50, 8'h10, 8'h00, 8'hA5, 0, -1, 1'b0, 1'b0);
    run_req("t3_nack", 1'b0, 7'h50, 8'h12, 8'h34, 8'h00, 0, 1, 1'b0, 1'b0);
    run_req("t4_slow", 1'b0, 7'h3C, 8'hF0, 8'h0F, 8'h00, 10, -1, 1'b0, 1'b0);
    run_req("t6_req_busy", 1'b1, 7'h11, 8'h22, 8'h00, 8'h5C, 2, -1, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      r = 1'($urandom_range(0, 1));
      d = 7'($urandom); ra = 8'($urandom); wd = 8'($urandom); rv = 8'($urandom);
      bp = $urandom_range(0, 10);
      nk = -1;
      if ($urandom_range(0, 1) == 1) begin
        nk = $urandom_range(1, 3);
        if (r && nk == 3) nk = 4;
      end
      run_req("rand", r, d, ra, wd, rv, bp, nk, 1'b0, 1'b0);
    end

    // Poll timeout on the second instance: core busy forever.
    @(negedge clk);
    w2 = 0; r2 = 0;
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_done", {31'h0, done2}, 32'h1);
    chk("t5_err", {31'h0, err2}, 32'h1);
    chk("t5_polls", r2, 4);
    chk("t5_writes", w2, 1);
    repeat (20) @(negedge clk);
    chk("t5_no_more_writes", w2, 1);
    chk("t5_no_more_polls", r2, 4);
    chk("t5_busy", {31'h0, busy2}, 32'h0);
    chk("t5_rdata", {24'h0, rdata2}, 32'h0);

    // Reset in the middle of a read transaction.
    busy_polls = 1; nack_at = -1; read_val = 8'h77; cmd_idx = 0; log_q.delete();
    @(negedge clk);
    rnw = 1'b1; dev_addr = 7'h50; reg_addr = 8'h10; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cyc = 0;
    while (cmd_idx < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_reached_step3", {31'h0, cmd_idx >= 3}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_m_ctl", {25'h0, bus.m_address, bus.m_chipselect, bus.m_write, bus.m_read}, 32'h0);
    chk("t6_async_m_wdata", bus.m_writedata, 32'h0);
    chk("t6_async_busy", {31'h0, busy}, 32'h0);
    sc = strobe_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_no_strobes", strobe_cnt, sc);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_err", {31'h0, err}, 32'h0);
    chk("t6_rdata", {24'h0, rdata}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
